tm_switch_ctrl: RTL and testbench

TM_SWITCH_CTRL -- requirements
Module: tm_switch_ctrl

---
 rtl/tm_switch_ctrl.sv | 156 +++++++++++++++
 tb/tb_tm_switch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tm_switch_ctrl.sv
// Test-mode switch controller for two IP instances.
// Arbitrates between two requesters and sequences each test_mode change:
// freeze the IP's input (drain), flip test_mode, let it settle, then ack.
//
// Handshake: req[i] is a level held by requester i until it sees ack[i].
// ack[i] is a single-cycle pulse marking completion. req_mode[i] is
// sampled only in the grant cycle. A requester that drops req after its
// grant still receives its ack; a request is never granted mid-transaction.
module tm_switch_ctrl #(
  parameter int DRAIN_CYC  = 4,
  parameter int SETTLE_CYC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] req_mode,
  output logic [1:0] ack,
  output logic [1:0] test_mode,
  output logic [1:0] in_hold,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    ACK    = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_LD  = 4'(DRAIN_CYC);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt_q, gnt_d;     // requester owning the current transaction
  logic       mode_q, mode_d;   // test_mode value sampled at grant
  logic       last_q, last_d;   // requester granted most recently
  logic [1:0] ack_q, ack_d;
  logic [1:0] hold_q, hold_d;
  logic [1:0] tm_q, tm_d;
  logic       busy_q, busy_d;

  logic       sel;              // arbitration winner among current requests
  logic [1:0] gnt_mask;

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    mode_d   = mode_q;
    last_d   = last_q;
    tm_d     = tm_q;
    sel      = 1'b0;
    gnt_mask = 2'b00;
    ack_d    = 2'b00;
    hold_d   = 2'b00;
    busy_d   = 1'b0;

    // Round-robin: on a tie the requester not granted last wins
    if (req == 2'b11) begin
      sel = ~last_q;
    end else begin
      sel = req[1];
    end

    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d  = sel;
          last_d = sel;
          mode_d = req_mode[sel];
          if (req_mode[sel] == tm_q[sel]) begin
            // Already in the requested mode: acknowledge without touching the IP
            state_d = ACK;
          end else begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LD;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd1) begin
          state_d = SWITCH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SWITCH: begin
        // test_mode flips on this edge, so it is visible in the first SETTLE cycle
        state_d     = SETTLE;
        cnt_d       = SETTLE_LD;
        tm_d[gnt_q] = mode_q;
      end
      SETTLE: begin
        if (cnt_q == 4'd1) begin
          state_d = ACK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    gnt_mask = gnt_d ? 2'b10 : 2'b01;
    ack_d    = (state_d == ACK) ? gnt_mask : 2'b00;
    // Hold spans DRAIN through the ACK that ends a real transition; a no-op ACK never holds
    if ((state_d == DRAIN) || (state_d == SWITCH) || (state_d == SETTLE) ||
        ((state_d == ACK) && (state_q == SETTLE))) begin
      hold_d = gnt_mask;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      mode_q  <= 1'b0;
      last_q  <= 1'b1;
      ack_q   <= 2'b00;
      hold_q  <= 2'b00;
      tm_q    <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      hold_q  <= hold_d;
      tm_q    <= tm_d;
      busy_q  <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign in_hold   = hold_q;
  assign test_mode = tm_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tm_switch_ctrl.sv
// Bench for tm_switch_ctrl: directed scenarios plus randomized requesters,
// all outputs compared each cycle against a transaction-timeline model.
module tb_tm_switch_ctrl;

  localparam int D  = 4;
  localparam int S  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req = 2'b00, req_mode = 2'b00;
  logic [1:0] ack, test_mode, in_hold;
  logic       busy;
  logic [2:0] dbg_state;

  logic [1:0] req2 = 2'b00, req_mode2 = 2'b00;
  logic [1:0] ack2, test_mode2, in_hold2;
  logic       busy2;
  logic [2:0] dbg_state2;

  tm_switch_ctrl #(.DRAIN_CYC(D), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_mode(req_mode),
    .ack(ack), .test_mode(test_mode), .in_hold(in_hold), .busy(busy),
    .dbg_state(dbg_state)
  );

  tm_switch_ctrl #(.DRAIN_CYC(1), .SETTLE_CYC(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_mode(req_mode2),
    .ack(ack2), .test_mode(test_mode2), .in_hold(in_hold2), .busy(busy2),
    .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard / checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One transaction at a time, described by its grant, its total length and
  // the offset (cycles since grant) of the current cycle.
  bit         m_active = 1'b0;
  bit         m_g      = 1'b0;
  bit         m_noop   = 1'b0;
  bit         m_mode   = 1'b0;
  bit         m_last   = 1'b1;
  int         m_off    = 0;
  int         m_lat    = 0;
  logic [1:0] m_tm     = 2'b00;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_last   = 1'b1;
        m_tm     = 2'b00;
        m_off    = 0;
      end else if (m_active) begin
        if (m_off == m_lat) begin
          m_active = 1'b0;
        end else begin
          m_off++;
          if (!m_noop && m_off == D + 2) m_tm[m_g] = m_mode;
        end
      end else if (req != 2'b00) begin
        if (req == 2'b01)      m_g = 1'b0;
        else if (req == 2'b10) m_g = 1'b1;
        else                   m_g = !m_last;
        m_last   = m_g;
        m_mode   = req_mode[m_g];
        m_noop   = (m_mode == m_tm[m_g]);
        m_lat    = m_noop ? 1 : D + S + 2;
        m_off    = 1;
        m_active = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_eq("busy", 32'(busy), 32'(m_active));
        check_eq("ack", 32'(ack),
                 (m_active && m_off == m_lat) ? 32'(2'b01 << m_g) : 32'd0);
        check_eq("in_hold", 32'(in_hold),
                 (m_active && !m_noop) ? 32'(2'b01 << m_g) : 32'd0);
        check_eq("test_mode", 32'(test_mode), 32'(m_tm));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    req = 2'b00; req_mode = 2'b00; req2 = 2'b00; req_mode2 = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_hold", 32'(in_hold), 32'd0);
    check_eq("rst_tm", 32'(test_mode), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
  endtask

  // Counts cycles from the current negedge until ack appears, then drops the acked req
  task automatic measure_ack(input string tag, input logic [1:0] exp_ack, input int exp_cyc);
    int k;
    k = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        k = n;
        break;
      end
    end
    check_eq({tag, "_lat"}, 32'(k), 32'(exp_cyc));
    check_eq({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    req = req & ~ack;
  endtask

  // Asynchronous reset pulse in mid-cycle, outputs checked before the next edge
  task automatic async_reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_ack"}, 32'(ack), 32'd0);
    check_eq({tag, "_hold"}, 32'(in_hold), 32'd0);
    check_eq({tag, "_tm"}, 32'(test_mode), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_tm, t_ack;

    do_reset();

    // Transition on requester 0 with default timing
    req = 2'b01; req_mode = 2'b01;
    measure_ack("xfer0", 2'b01, 9);
    check_eq("xfer0_tm", 32'(test_mode), 32'd1);

    // Same mode again: no-op, acked one cycle after grant
    @(negedge clk);
    req = 2'b01; req_mode = 2'b01;
    measure_ack("noop", 2'b01, 1);
    check_eq("noop_hold", 32'(in_hold), 32'd0);
    check_eq("noop_tm", 32'(test_mode), 32'd1);
    @(negedge clk);

    // Tie from reset: requester 0 first, then requester 1
    do_reset();
    req = 2'b11; req_mode = 2'b11;
    measure_ack("tie0", 2'b01, 9);
    measure_ack("tie1", 2'b10, 10);
    check_eq("tie_tm", 32'(test_mode), 32'd3);
    @(negedge clk);

    // Request held only for the grant cycle still completes
    do_reset();
    req = 2'b01; req_mode = 2'b01;
    @(negedge clk);
    req = 2'b00; req_mode = 2'b00;
    measure_ack("pulse", 2'b01, 8);
    @(negedge clk);

    // Reset in cycle 7 of a transition; held request re-grants after release
    do_reset();
    req = 2'b01; req_mode = 2'b01;
    repeat (7) @(negedge clk);
    async_reset_pulse("midrst");
    measure_ack("regrant", 2'b01, 9);
    @(negedge clk);

    // Shortest timing: DRAIN_CYC=1, SETTLE_CYC=1
    req2 = 2'b01; req_mode2 = 2'b01;
    t_tm = 0; t_ack = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (t_tm == 0 && test_mode2 == 2'b01) t_tm = n;
      if (ack2 != 2'b00) begin
        t_ack = n;
        check_eq("fast_ack", 32'(ack2), 32'd1);
        req2 = 2'b00;
        break;
      end
    end
    check_eq("fast_tm_cyc", 32'(t_tm), 32'd3);
    check_eq("fast_ack_cyc", 32'(t_ack), 32'd4);

    // Randomized requesters, occasional early drop, mode flips and resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
          if ($urandom_range(0, 9) == 0) req_mode[i] = ~req_mode[i];
        end else if ($urandom_range(0, 3) == 0) begin
          req[i]      = 1'b1;
          req_mode[i] = 1'($urandom_range(0, 1));
        end
      end
      if ($urandom_range(0, 399) == 0) async_reset_pulse("rndrst");
    end

    req = 2'b00;
    repeat (20) @(negedge clk);
    check_eq("end_busy", 32'(busy), 32'd0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
